vga_scaler_pipe: RTL and testbench

Parametrised framebuffer-to-VGA scaler that replaces the fixed 2× upscaler between the VGA timing generator and the camera framebuffer. It converts screen coordinates into framebuffer read addresses for a runtime-selectable integer zoom (1×, 2×, 4×) and centres the scaled image in the display with a programmable border colour. It converts RGB565 to an N-bit-per-channel DAC output and delays sync signals to match a configurable memory read latency. A built-in colour-bar mode supports bring-up without a camera.

---
 rtl/vga_scaler_pkg.sv | 34 +++
 rtl/vga_delay_line.sv | 28 ++
 rtl/vga_scaler_pipe.sv | 168 ++++++++++++++++
 tb/tb_vga_scaler_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_scaler_pkg.sv
// Shared definitions for the framebuffer-to-VGA scaler: zoom encodings,
// RGB565 field positions and small geometry / colour-bar helpers.
package vga_scaler_pkg;

  localparam logic [1:0] SCALE_1X = 2'd0;
  localparam logic [1:0] SCALE_2X = 2'd1;
  localparam logic [1:0] SCALE_4X = 2'd2;

  // MSB position of each channel inside an RGB565 word
  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_B_MSB = 4;

  // Zoom select to shift amount; the unused code 3 falls back to 2x
  function automatic logic [1:0] sel_to_shift(input logic [1:0] sel);
    case (sel)
      SCALE_1X: return 2'd0;
      SCALE_4X: return 2'd2;
      default:  return 2'd1;
    endcase
  endfunction

  // Centring offset; an image larger than the display is pinned to the origin
  function automatic logic [11:0] win_origin(input logic [11:0] dst,
                                             input logic [11:0] scaled);
    return (scaled <= dst) ? ((dst - scaled) >> 1) : 12'd0;
  endfunction

  // Colour-bar index: eight 128-pixel bars, bits map to {R,G,B} enables
  function automatic logic [2:0] color_bar_idx(input logic [9:0] x);
    return x[9:7];
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to align syncs and pixel flags with the
// framebuffer read latency.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per pixel clock, all stages forced to RST_VAL in reset
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scaler_pipe.sv
// Framebuffer-to-VGA scaler: integer zoom address generation without a
// multiplier, centred image window with border colour, RGB565 to OUT_W-bit
// conversion, colour-bar test mode and latency-matched syncs.
module vga_scaler_pipe #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int DST_W  = 640,
  parameter int DST_H  = 480,
  parameter int ADDR_W = 17,
  parameter int OUT_W  = 3,
  parameter int RD_LAT = 1
) (
  input  logic                 vga_clk,
  input  logic                 rst_n,
  input  logic [9:0]           x_pixel,
  input  logic [9:0]           y_pixel,
  input  logic                 data_enable,
  input  logic                 VGAHS_in,
  input  logic                 VGAVS_in,
  input  logic [1:0]           scale_sel,
  input  logic                 test_mode,
  input  logic [3*OUT_W-1:0]   border_color,
  output logic                 fb_rd_en,
  output logic [ADDR_W-1:0]    fb_rd_addr,
  input  logic [15:0]          fb_pixel,
  output logic [OUT_W-1:0]     VGA_R,
  output logic [OUT_W-1:0]     VGA_G,
  output logic [OUT_W-1:0]     VGA_B,
  output logic                 VGAHS,
  output logic                 VGAVS,
  output logic                 frame_start
);

  import vga_scaler_pkg::*;

  logic [1:0]        scale_s;
  logic              vs_prev, de_prev;
  logic              vs_fall, de_fall;
  logic [ADDR_W-1:0] row_base;
  logic [1:0]        sub_row;
  logic [1:0]        sub_last;
  logic              row_hit;
  logic [11:0]       sw, sh, x0, y0, xp, yp, x_off, y_off;
  logic              in_win, rd_fire;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [1:0]        sync_q;
  logic              de_d;
  logic [4:0]        flags_d;
  logic              win_d, test_d;
  logic [2:0]        bar_d;
  logic              unused_fb_bits;

  assign vs_fall = vs_prev & ~VGAVS_in;
  assign de_fall = de_prev & ~data_enable;

  // Window geometry for the latched zoom and the in-window test for this pixel
  always_comb begin
    sw       = 12'(SRC_W) << scale_s;
    sh       = 12'(SRC_H) << scale_s;
    x0       = win_origin(12'(DST_W), sw);
    y0       = win_origin(12'(DST_H), sh);
    xp       = {2'b00, x_pixel};
    yp       = {2'b00, y_pixel};
    x_off    = xp - x0;
    y_off    = yp - y0;
    in_win   = data_enable
             && (xp >= x0) && (x_off < sw) && (xp < 12'(DST_W))
             && (yp >= y0) && (y_off < sh) && (yp < 12'(DST_H));
    rd_fire  = in_win & ~test_mode;
    sub_last = 2'((3'd1 << scale_s) - 3'd1);
    rd_addr_next = row_base + ADDR_W'(x_off >> scale_s);
  end

  // Scale latch, frame pulse, row/sub-row tracking and the registered read port
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      vs_prev     <= 1'b1;
      de_prev     <= 1'b0;
      scale_s     <= sel_to_shift(scale_sel);
      frame_start <= 1'b0;
      row_base    <= '0;
      sub_row     <= '0;
      row_hit     <= 1'b0;
      fb_rd_en    <= 1'b0;
      fb_rd_addr  <= '0;
    end else begin
      vs_prev     <= VGAVS_in;
      de_prev     <= data_enable;
      frame_start <= vs_fall;
      if (vs_fall) scale_s <= sel_to_shift(scale_sel);

      // The vertical reset takes priority over a line ending in the same cycle
      if (vs_fall) begin
        row_base <= '0;
        sub_row  <= '0;
        row_hit  <= 1'b0;
      end else if (de_fall) begin
        row_hit <= 1'b0;
        if (row_hit) begin
          if (sub_row == sub_last) begin
            sub_row  <= '0;
            row_base <= row_base + ADDR_W'(SRC_W);
          end else begin
            sub_row <= sub_row + 2'd1;
          end
        end
      end else if (in_win) begin
        row_hit <= 1'b1;
      end

      fb_rd_en <= rd_fire;
      if (rd_fire) fb_rd_addr <= rd_addr_next;
    end
  end

  // Syncs need the full latency; the output register below adds the last stage for DE/flags
  vga_delay_line #(.WIDTH(2), .DEPTH(RD_LAT + 2), .RST_VAL(2'b11)) u_sync_dl (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .din     ({VGAHS_in, VGAVS_in}),
    .dout    (sync_q)
  );

  vga_delay_line #(.WIDTH(1), .DEPTH(RD_LAT + 1), .RST_VAL(1'b0)) u_de_dl (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .din     (data_enable),
    .dout    (de_d)
  );

  vga_delay_line #(.WIDTH(5), .DEPTH(RD_LAT + 1), .RST_VAL(5'b0)) u_flag_dl (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .din     ({in_win, test_mode, color_bar_idx(x_pixel)}),
    .dout    (flags_d)
  );

  assign VGAHS  = sync_q[1];
  assign VGAVS  = sync_q[0];
  assign win_d  = flags_d[4];
  assign test_d = flags_d[3];
  assign bar_d  = flags_d[2:0];

  // Only the top OUT_W bits of each channel reach the DAC
  assign unused_fb_bits = ^fb_pixel;

  // Output colour mux: blanking, colour bars, framebuffer pixel or border
  always_ff @(posedge vga_clk) begin
    if (!rst_n || !de_d) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else if (test_d) begin
      VGA_R <= {OUT_W{bar_d[2]}};
      VGA_G <= {OUT_W{bar_d[1]}};
      VGA_B <= {OUT_W{bar_d[0]}};
    end else if (win_d) begin
      VGA_R <= fb_pixel[RGB565_R_MSB -: OUT_W];
      VGA_G <= fb_pixel[RGB565_G_MSB -: OUT_W];
      VGA_B <= fb_pixel[RGB565_B_MSB -: OUT_W];
    end else begin
      VGA_R <= border_color[3*OUT_W-1 -: OUT_W];
      VGA_G <= border_color[2*OUT_W-1 -: OUT_W];
      VGA_B <= border_color[OUT_W-1:0];
    end
  end

endmodule

// File: tb/tb_vga_scaler_pipe.sv
// Directed bench for vga_scaler_pipe. Four instances share the stimulus with
// RD_LAT 1..4; each has a memory model that returns the address as data.
// Instance 0 (RD_LAT=1) carries the functional checks.
module tb_vga_scaler_pipe;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic [9:0]  x_pixel, y_pixel;
  logic        data_enable, hs_in, vs_in, test_mode;
  logic [1:0]  scale_sel;
  logic [8:0]  border_color;

  logic [3:0]  rd_en_o, hs_o, vs_o, fs_o;
  logic [16:0] rd_addr_o [4];
  logic [15:0] fb_px [4];
  logic [2:0]  red_o [4], grn_o [4], blu_o [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  for (genvar k = 0; k < 4; k++) begin : g_lat
    logic [16:0] mq [0:k];

    // Synchronous memory with RD_LAT cycles of latency, data = address
    always @(posedge vga_clk) begin
      mq[0] <= rd_addr_o[k];
      for (int i = 1; i <= k; i++) mq[i] <= mq[i-1];
    end
    assign fb_px[k] = mq[k][15:0];

    vga_scaler_pipe #(.RD_LAT(k + 1)) u_dut (
      .vga_clk      (vga_clk),
      .rst_n        (rst_n),
      .x_pixel      (x_pixel),
      .y_pixel      (y_pixel),
      .data_enable  (data_enable),
      .VGAHS_in     (hs_in),
      .VGAVS_in     (vs_in),
      .scale_sel    (scale_sel),
      .test_mode    (test_mode),
      .border_color (border_color),
      .fb_rd_en     (rd_en_o[k]),
      .fb_rd_addr   (rd_addr_o[k]),
      .fb_pixel     (fb_px[k]),
      .VGA_R        (red_o[k]),
      .VGA_G        (grn_o[k]),
      .VGA_B        (blu_o[k]),
      .VGAHS        (hs_o[k]),
      .VGAVS        (vs_o[k]),
      .frame_start  (fs_o[k])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic vs_fall(input string tag);
    vs_in = 1'b0;
    tick();
    check({tag, "_fs1"}, fs_o[0], 1);
    vs_in = 1'b1;
    tick();
    check({tag, "_fs0"}, fs_o[0], 0);
  endtask

  // One pixel then end of line; checks the read strobe and address
  task automatic pix_chk(input string tag, input int x, input int y, input int exp_addr);
    x_pixel = 10'(x); y_pixel = 10'(y); data_enable = 1'b1;
    tick();
    check({tag, "_en"}, rd_en_o[0], 1);
    check({tag, "_addr"}, rd_addr_o[0], exp_addr);
    data_enable = 1'b0;
    tick();
  endtask

  // Same as pix_chk plus colour and HS alignment at t+2 / t+3
  task automatic pix_full(input string tag, input int x, input int y, input int exp_addr,
                          input int er, input int eg, input int eb);
    x_pixel = 10'(x); y_pixel = 10'(y); data_enable = 1'b1; hs_in = 1'b0;
    tick();
    check({tag, "_en"}, rd_en_o[0], 1);
    check({tag, "_addr"}, rd_addr_o[0], exp_addr);
    data_enable = 1'b0; hs_in = 1'b1;
    tick();
    check({tag, "_hs_t2"}, hs_o[0], 1);
    check({tag, "_b_t2"}, blu_o[0], 0);
    tick();
    check({tag, "_hs_t3"}, hs_o[0], 0);
    check({tag, "_r"}, red_o[0], er);
    check({tag, "_g"}, grn_o[0], eg);
    check({tag, "_b"}, blu_o[0], eb);
  endtask

  task automatic drive_row(input int x, input int y);
    x_pixel = 10'(x); y_pixel = 10'(y); data_enable = 1'b1;
    tick();
    data_enable = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; x_pixel = '0; y_pixel = '0; data_enable = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; scale_sel = 2'd1; test_mode = 1'b0;
    border_color = 9'b101_010_011;
    repeat (3) tick();
    check("rst_en", rd_en_o[0], 0);
    check("rst_addr", rd_addr_o[0], 0);
    check("rst_r", red_o[0], 0);
    check("rst_g", grn_o[0], 0);
    check("rst_b", blu_o[0], 0);
    check("rst_hs", hs_o[0], 1);
    check("rst_vs", vs_o[0], 1);
    check("rst_fs", fs_o[0], 0);
    rst_n = 1'b1;
    tick();

    // 2x zoom, full 480-row frame with one or two pixels per row
    vs_fall("x2");
    pix_chk("x2_0_0", 0, 0, 0);
    pix_full("x2_639_1", 639, 1, 319, 0, 1, 7);
    pix_chk("x2_0_2", 0, 2, 320);
    for (int y = 3; y < 479; y++) drive_row(0, y);
    pix_full("x2_639_479", 639, 479, 76799, 1, 3, 7);

    // 1x zoom: centred window at (160,120) with border around it
    scale_sel = 2'd0;
    vs_fall("x1");
    x_pixel = 10'd160; y_pixel = 10'd120; data_enable = 1'b1;
    tick();
    check("x1_160_en", rd_en_o[0], 1);
    check("x1_160_addr", rd_addr_o[0], 0);
    x_pixel = 10'd159;
    tick();
    check("x1_159_en", rd_en_o[0], 0);
    check("x1_159_hold", rd_addr_o[0], 0);
    data_enable = 1'b0;
    tick();
    check("x1_160_b", blu_o[0], 0);
    tick();
    check("x1_bord_r", red_o[0], 5);
    check("x1_bord_g", grn_o[0], 2);
    check("x1_bord_b", blu_o[0], 3);
    for (int y = 121; y < 359; y++) drive_row(160, y);
    pix_full("x1_479_359", 479, 359, 76799, 1, 3, 7);

    // 4x zoom and a mid-frame scale change that must wait for VS
    scale_sel = 2'd2;
    vs_fall("x4");
    pix_chk("x4_4_4", 4, 4, 1);
    scale_sel = 2'd0;
    pix_chk("x4_mid", 8, 5, 2);
    vs_fall("x4_to_x1");
    x_pixel = 10'd4; y_pixel = 10'd4; data_enable = 1'b1;
    tick();
    check("x1_after_en", rd_en_o[0], 0);
    data_enable = 1'b0;
    tick();

    // Colour bars
    test_mode = 1'b1; y_pixel = 10'd200; data_enable = 1'b1;
    x_pixel = 10'd0;
    tick();
    check("tm0_en", rd_en_o[0], 0);
    x_pixel = 10'd128;
    tick();
    check("tm128_en", rd_en_o[0], 0);
    x_pixel = 10'd512;
    tick();
    check("tm512_en", rd_en_o[0], 0);
    check("tm0_r", red_o[0], 0);
    check("tm0_g", grn_o[0], 0);
    check("tm0_b", blu_o[0], 0);
    data_enable = 1'b0;
    tick();
    check("tm128_r", red_o[0], 0);
    check("tm128_b", blu_o[0], 7);
    tick();
    check("tm512_r", red_o[0], 7);
    check("tm512_b", blu_o[0], 0);
    test_mode = 1'b0;
    tick();

    // Latency sweep: HS edge and first coloured pixel land at L = RD_LAT+2
    scale_sel = 2'd1;
    vs_fall("sweep");
    x_pixel = 10'd638; y_pixel = 10'd0; data_enable = 1'b1; hs_in = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 1) begin
        data_enable = 1'b0;
        hs_in = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        if (n == k + 2) begin
          check($sformatf("lat%0d_hs_pre", k + 1), hs_o[k], 1);
          check($sformatf("lat%0d_b_pre", k + 1), blu_o[k], 0);
        end
        if (n == k + 3) begin
          check($sformatf("lat%0d_hs", k + 1), hs_o[k], 0);
          check($sformatf("lat%0d_b", k + 1), blu_o[k], 7);
        end
      end
    end

    // Reset in the middle of a line
    x_pixel = 10'd638; y_pixel = 10'd0; data_enable = 1'b1; hs_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_r", red_o[0], 0);
    check("mrst_g", grn_o[0], 0);
    check("mrst_b", blu_o[0], 0);
    check("mrst_hs", hs_o[0], 1);
    check("mrst_vs", vs_o[0], 1);
    check("mrst_en", rd_en_o[0], 0);
    rst_n = 1'b1; data_enable = 1'b0; hs_in = 1'b1;
    tick();
    pix_chk("prevs_2_0", 2, 0, 1);
    vs_fall("post_rst");
    pix_chk("prst_0_0", 0, 0, 0);
    pix_chk("prst_638_1", 638, 1, 319);
    pix_chk("prst_0_2", 0, 2, 320);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
